// File: rtl/stereo_pkg.sv
// Shared types for the stereo frame path: frame geometry defaults and the
// per-pixel position tag that travels alongside BRAM read data.
package stereo_pkg;

    localparam int FRAME_H = 320;
    localparam int FRAME_V = 240;
    localparam int PIXEL_W = 16;
    localparam int TAG_W   = 16;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef struct packed {
        logic [TAG_W-1:0] h;
        logic [TAG_W-1:0] v;
        logic             last;
    } pix_tag_t;

    function automatic pix_tag_t make_tag(input logic [TAG_W-1:0] h,
                                          input logic [TAG_W-1:0] v,
                                          input logic             last);
        pix_tag_t t;
        t.h    = h;
        t.v    = v;
        t.last = last;
        return t;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered storage; the head entry is presented
// directly from storage and an occupancy count is exported for credit tracking.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_index_reader.sv
// Sweeps the frame BRAM in raster order on new_frame_in and streams each pixel
// with its (h,v,last) tag; reads are credit-limited so backpressure never drops data.
module frame_index_reader
    import stereo_pkg::*;
#(
    parameter int H_PIXELS    = FRAME_H,
    parameter int V_PIXELS    = FRAME_V,
    parameter int PIXEL_WIDTH = PIXEL_W,
    parameter int RAM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  new_frame_in,
    output logic [$clog2(H_PIXELS*V_PIXELS)-1:0]  addr_out,
    output logic                                  ram_en_out,
    input  logic [PIXEL_WIDTH-1:0]                ram_data_in,
    output logic [PIXEL_WIDTH-1:0]                pixel_out,
    output logic [$clog2(H_PIXELS)-1:0]           hcount_out,
    output logic [$clog2(V_PIXELS)-1:0]           vcount_out,
    output logic                                  last_out,
    output logic                                  valid_out,
    input  logic                                  ready_in,
    output logic                                  busy_out
);

    localparam int NPIX = H_PIXELS * V_PIXELS;
    localparam int AW   = $clog2(NPIX);
    localparam int HW   = $clog2(H_PIXELS);
    localparam int VW   = $clog2(V_PIXELS);
    localparam int CW   = $clog2(FIFO_DEPTH+1);
    localparam int TW   = $bits(pix_tag_t);
    localparam int FW   = PIXEL_WIDTH + TW;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state;
    logic [HW-1:0]          h_cnt;
    logic [VW-1:0]          v_cnt;
    logic [RAM_LATENCY-1:0] en_pipe;
    pix_tag_t               tag_pipe [RAM_LATENCY];
    logic [CW-1:0]          in_flight;
    logic [CW-1:0]          fifo_count;
    logic                   issue;
    logic                   last_issue;
    logic                   pop;
    logic [FW-1:0]          fifo_head;
    pix_tag_t               head_tag;
    logic                   unused_tag_bits;

    assign in_flight  = CW'($countones(en_pipe));
    assign last_issue = (addr_out == AW'(NPIX-1));
    // Credit excludes a same-cycle pop, so the FIFO can never be overrun.
    assign issue      = (state == ISSUE) &&
                        (({1'b0, in_flight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
    assign ram_en_out = issue;

    assign valid_out  = (fifo_count != '0);
    assign pop        = valid_out && ready_in;
    assign head_tag   = pix_tag_t'(fifo_head[TW-1:0]);
    assign pixel_out  = fifo_head[FW-1 -: PIXEL_WIDTH];
    assign hcount_out = head_tag.h[HW-1:0];
    assign vcount_out = head_tag.v[VW-1:0];
    assign last_out   = valid_out && head_tag.last;
    assign busy_out   = (state != IDLE);

    assign unused_tag_bits = ^{head_tag.h, head_tag.v};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            addr_out <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            en_pipe  <= '0;
            for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            en_pipe[0]  <= issue;
            tag_pipe[0] <= make_tag(TAG_W'(h_cnt), TAG_W'(v_cnt), last_issue);
            for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                en_pipe[i]  <= en_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end

            case (state)
                IDLE: begin
                    if (new_frame_in) begin
                        state    <= ISSUE;
                        addr_out <= '0;
                        h_cnt    <= '0;
                        v_cnt    <= '0;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        if (last_issue) begin
                            state <= DRAIN;
                        end else begin
                            addr_out <= addr_out + 1'b1;
                            if (h_cnt == HW'(H_PIXELS-1)) begin
                                h_cnt <= '0;
                                v_cnt <= v_cnt + 1'b1;
                            end else begin
                                h_cnt <= h_cnt + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_tag.last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (en_pipe[RAM_LATENCY-1]),
        .push_data ({ram_data_in, tag_pipe[RAM_LATENCY-1]}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_frame_index_reader.sv
// Bench for frame_index_reader on a 4x3 frame with a 2-cycle read-first BRAM
// whose contents equal the address; a queue model tracks the pixels owed downstream.
module tb_frame_index_reader;

    localparam int H     = 4;
    localparam int V     = 3;
    localparam int N     = H * V;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        new_frame_in;
    logic [3:0]  addr_out;
    logic        ram_en_out;
    logic [15:0] ram_data_in;
    logic [15:0] pixel_out;
    logic [1:0]  hcount_out;
    logic [1:0]  vcount_out;
    logic        last_out;
    logic        valid_out;
    logic        ready_in;
    logic        busy_out;

    frame_index_reader #(
        .H_PIXELS    (H),
        .V_PIXELS    (V),
        .PIXEL_WIDTH (16),
        .RAM_LATENCY (2),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .new_frame_in (new_frame_in),
        .addr_out     (addr_out),
        .ram_en_out   (ram_en_out),
        .ram_data_in  (ram_data_in),
        .pixel_out    (pixel_out),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out),
        .last_out     (last_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;

    // Single-port read-first BRAM, read-only here, preloaded with data = address.
    logic [15:0] ram_mem [16];
    logic [15:0] ram_r1 = '0;
    logic [15:0] ram_r2 = '0;
    initial begin
        for (int i = 0; i < 16; i++) ram_mem[i] = 16'(i);
    end
    always @(posedge clk) begin
        if (ram_en_out) ram_r1 <= ram_mem[addr_out];
        ram_r2 <= ram_r1;
    end
    assign ram_data_in = ram_r2;

    int checks = 0;
    int errors = 0;

    // Model state: pixels owed downstream, in order.
    int q[$];
    bit model_busy = 0;
    int issue_idx = 0;
    int frame_pops = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_valid_cyc = 0;
    int last_pop_cyc = 0;
    bit seen_valid = 0;
    int stall_cnt = 0;
    bit hold = 0;
    int hold_pix = 0, hold_h = 0, hold_v = 0, hold_last = 0;
    bit pulsed = 0;

    int pat[12] = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 1};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs against the model at the falling edge,
    // advance the model by what the coming rising edge will do, then return
    // just after that edge so the caller can drive the next cycle's inputs.
    task automatic step();
        int  e;
        bit  done;
        bit  start;
        @(negedge clk);
        cyc++;
        if (rst_in) begin
            q.delete();
            model_busy = 0;
            issue_idx  = 0;
            frame_pops = 0;
            seen_valid = 0;
            hold       = 0;
        end else begin
            done = 0;
            chk("busy", int'(busy_out), int'(model_busy));
            if (hold) begin
                chk("hold_valid", int'(valid_out), 1);
                chk("hold_pixel", int'(pixel_out), hold_pix);
                chk("hold_h", int'(hcount_out), hold_h);
                chk("hold_v", int'(vcount_out), hold_v);
                chk("hold_last", int'(last_out), hold_last);
            end
            if (valid_out) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    e = q[0];
                    chk("pixel", int'(pixel_out), e);
                    chk("hcount", int'(hcount_out), e % H);
                    chk("vcount", int'(vcount_out), e / H);
                    chk("last", int'(last_out), int'(e == N-1));
                end
                if (!seen_valid) begin
                    seen_valid = 1;
                    first_valid_cyc = cyc;
                end
            end else begin
                chk("last_when_idle", int'(last_out), 0);
            end
            if (ram_en_out) begin
                chk("ram_en_busy", int'(model_busy), 1);
                chk("issue_bound", int'(issue_idx < N), 1);
                chk("addr", int'(addr_out), issue_idx);
                chk("credit", int'(issue_idx - frame_pops < DEPTH), 1);
                issue_idx++;
            end else if (model_busy && issue_idx < N) begin
                stall_cnt++;
            end
            hold      = valid_out && !ready_in;
            hold_pix  = int'(pixel_out);
            hold_h    = int'(hcount_out);
            hold_v    = int'(vcount_out);
            hold_last = int'(last_out);
            if (valid_out && ready_in && q.size() > 0) begin
                e = q.pop_front();
                frame_pops++;
                last_pop_cyc = cyc;
                if (e == N-1) done = 1;
            end
            start = new_frame_in && !model_busy;
            if (done) model_busy = 0;
            if (start) begin
                model_busy = 1;
                q.delete();
                for (int i = 0; i < N; i++) q.push_back(i);
                issue_idx  = 0;
                frame_pops = 0;
                seen_valid = 0;
                start_cyc  = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready held high; mode 1: ready follows pat[]; mode 2: ready low.
    function automatic logic rdy(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[n % 12] != 0;
        return 1'b0;
    endfunction

    task automatic run_frame(input int mode, input int repulse_at, input bit end_pulse);
        int n = 0;
        pulsed       = 0;
        new_frame_in = 1'b1;
        ready_in     = rdy(mode, 0);
        step();
        new_frame_in = 1'b0;
        while (model_busy && n < 300) begin
            n++;
            ready_in     = rdy(mode, n);
            new_frame_in = 1'b0;
            if (repulse_at >= 0 && frame_pops == repulse_at && !pulsed) begin
                new_frame_in = 1'b1;
                pulsed = 1;
            end
            if (end_pulse && valid_out && last_out && ready_in) new_frame_in = 1'b1;
            step();
        end
        new_frame_in = 1'b0;
        if (model_busy) chk("frame_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, int'(addr_out), 0);
        chk({tag, "_ram_en"}, int'(ram_en_out), 0);
        chk({tag, "_valid"}, int'(valid_out), 0);
        chk({tag, "_last"}, int'(last_out), 0);
        chk({tag, "_busy"}, int'(busy_out), 0);
        chk({tag, "_pixel"}, int'(pixel_out), 0);
        chk({tag, "_h"}, int'(hcount_out), 0);
        chk({tag, "_v"}, int'(vcount_out), 0);
    endtask

    initial begin
        int n;
        rst_in       = 1'b1;
        new_frame_in = 1'b0;
        ready_in     = 1'b1;
        repeat (3) step();
        rst_in = 1'b0;
        chk_all_zero("reset");

        // Streaming frame with ready held high.
        run_frame(0, -1, 0);
        chk("first_latency", first_valid_cyc - start_cyc, 4);
        chk("frame_span", last_pop_cyc - first_valid_cyc, N-1);
        chk("frame_pixels", frame_pops, N);
        chk("busy_after", int'(busy_out), 0);
        repeat (3) step();

        // Irregular backpressure must stall issue on credit and lose nothing.
        stall_cnt = 0;
        run_frame(1, -1, 0);
        chk("pat_pixels", frame_pops, N);
        chk("credit_stall_seen", int'(stall_cnt > 0), 1);
        repeat (2) step();

        // Downstream blocked from the start: exactly DEPTH reads, then silence.
        new_frame_in = 1'b1;
        ready_in     = 1'b0;
        step();
        new_frame_in = 1'b0;
        repeat (20) step();
        chk("blocked_reads", issue_idx, DEPTH);
        chk("blocked_valid", int'(valid_out), 1);
        chk("blocked_ram_en", int'(ram_en_out), 0);
        chk("blocked_head", int'(pixel_out), 0);
        n = 0;
        ready_in = 1'b1;
        while (model_busy && n < 100) begin
            n++;
            step();
        end
        chk("blocked_drained", frame_pops, N);
        chk("blocked_idle", int'(busy_out), 0);

        // Re-pulse mid-frame is ignored; back-to-back frame the cycle after last pop.
        run_frame(0, 5, 0);
        chk("repulse_pixels", frame_pops, N);
        chk("repulse_reads", issue_idx, N);
        run_frame(0, -1, 1);
        chk("b2b_pixels", frame_pops, N);
        // A pulse in the final-pop cycle was ignored, so this one starts cleanly.
        chk("endpulse_idle", int'(busy_out), 0);
        run_frame(0, -1, 0);
        chk("after_endpulse_pixels", frame_pops, N);

        // Reset mid-frame with reads in flight.
        new_frame_in = 1'b1;
        ready_in     = 1'b1;
        step();
        new_frame_in = 1'b0;
        n = 0;
        while (frame_pops < 6 && n < 100) begin
            n++;
            step();
        end
        chk("pre_reset_pops", frame_pops, 6);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk_all_zero("midreset");
        repeat (4) step();
        chk("post_reset_valid", int'(valid_out), 0);
        run_frame(0, -1, 0);
        chk("post_reset_pixels", frame_pops, N);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
